// File: rtl/div_defs.sv
// Shared definitions for the sequential restoring divider: FSM encoding and widths.
package div_defs;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division step: (WIDTH+1)-bit partial remainder minus divisor, with borrow detect.
module div_sub_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             no_borrow_o
);

  logic [WIDTH+1:0] trial;
  logic             unused_trial_msb;

  // One extra bit above the operands captures the borrow out.
  assign trial            = {1'b0, rem_i} - {2'b00, divisor_i};
  assign no_borrow_o      = ~trial[WIDTH+1];
  // When there is no borrow the difference is below the divisor, so it fits WIDTH bits.
  assign diff_o           = trial[WIDTH-1:0];
  assign unused_trial_msb = trial[WIDTH];

endmodule

// File: rtl/div32_seq.sv
// Iterative restoring divider, one quotient bit per cycle, for DIV/DIVU/REM/REMU.
// Signed operation is compiled in only when DIV32_SIGNED_EN is defined.
module div32_seq
  import div_defs::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] dd_mag, dv_mag;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] sub_diff;
  logic             sub_no_borrow;
  logic             accept;

  assign accept = (state_q == IDLE) && start;
  assign rem_sh = {rem_q, dq_q[WIDTH-1]};

  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .rem_i       (rem_sh),
    .divisor_i   (dvsr_q),
    .diff_o      (sub_diff),
    .no_borrow_o (sub_no_borrow)
  );

`ifdef DIV32_SIGNED_EN
  logic neg_q_q, neg_q_d;
  logic neg_r_q, neg_r_d;
  logic dd_neg, dv_neg;

  assign dd_neg  = is_signed & dividend[WIDTH-1];
  assign dv_neg  = is_signed & divisor[WIDTH-1];
  assign dd_mag  = dd_neg ? (~dividend + WIDTH'(1)) : dividend;
  assign dv_mag  = dv_neg ? (~divisor + WIDTH'(1)) : divisor;
  assign neg_q_d = accept ? (dd_neg ^ dv_neg) : neg_q_q;
  assign neg_r_d = accept ? dd_neg : neg_r_q;
  assign q_fix   = neg_q_q ? (~dq_q + WIDTH'(1)) : dq_q;
  assign r_fix   = neg_r_q ? (~rem_q + WIDTH'(1)) : rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign dd_mag           = dividend;
  assign dv_mag           = divisor;
  assign q_fix            = dq_q;
  assign r_fix            = rem_q;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d  = CNT_W'(WIDTH - 1);
          rem_d  = '0;
          dvsr_d = dv_mag;
          dbz_d  = (divisor == '0);
          // On divide-by-zero the raw dividend is kept so FIX can return it untouched.
          dq_d    = (divisor == '0) ? dividend : dd_mag;
          state_d = (divisor == '0) ? FIX : RUN;
        end
      end
      RUN: begin
        dq_d  = {dq_q[WIDTH-2:0], sub_no_borrow};
        rem_d = sub_no_borrow ? sub_diff : rem_sh[WIDTH-1:0];
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        if (dbz_q) begin
          quot_d = '1;
          remo_d = dq_q;
        end else begin
          quot_d = q_fix;
          remo_d = r_fix;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule
